jk_bank_seq: RTL and testbench

//  Command sequencer for an external bank of WIDTH un-clearable JK flip-flops.
//  - Drives per-bit J/K vectors into the bank and reads back Q.
//  - Accepts ops over a valid/ready handshake: clear, set, toggle, load,

---
 rtl/jk_bank_seq.sv | 153 +++++++++++++++
 tb/tb_jk_bank_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_seq.sv
// Command sequencer for an external bank of un-clearable JK flip-flops.
// Clears the bank out of reset, then executes clear/set/toggle/load/increment/shift ops.
module jk_bank_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_* are ignored whenever cmd_ready is low.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_cnt,
  input  logic             abort,
  input  logic [WIDTH-1:0] jk_q,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_SET  = 3'd2;
  localparam logic [2:0] OP_TOG  = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_data;
  logic [CNTW-1:0]  r_cnt;
  logic             r_done;
  logic             r_aborted;

  logic             w_accept;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  assign w_accept = cmd_valid && cmd_ready;

  // Bits that flip in q+1 are exactly those whose lower bits are all ones.
  assign w_inc = jk_q + WIDTH'(1);
  assign w_tog = jk_q ^ w_inc;
  assign w_shl = {jk_q[WIDTH-2:0], r_data[0]};
  assign w_shr = {r_data[WIDTH-1], jk_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_op      <= OP_NOP;
      r_mask    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_mask  <= cmd_mask;
            r_data  <= cmd_data;
            r_cnt   <= (cmd_op >= OP_INC) ? cmd_cnt : '0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Abort takes priority over normal completion on the last cycle.
          if (abort) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    jk_j = '0;
    jk_k = '0;
    case (r_state)
      ST_INIT: jk_k = '1;
      ST_EXEC: begin
        if (!abort) begin
          case (r_op)
            OP_CLR:  jk_k = r_mask;
            OP_SET:  jk_j = r_mask;
            OP_TOG: begin
              jk_j = r_mask;
              jk_k = r_mask;
            end
            OP_LOAD: begin
              jk_j = r_data & r_mask;
              jk_k = ~r_data & r_mask;
            end
            OP_INC: begin
              jk_j = w_tog & r_mask;
              jk_k = w_tog & r_mask;
            end
            OP_SHL: begin
              jk_j = w_shl & r_mask;
              jk_k = ~w_shl & r_mask;
            end
            OP_SHR: begin
              jk_j = w_shr & r_mask;
              jk_k = ~w_shr & r_mask;
            end
            default: begin
              jk_j = '0;
              jk_k = '0;
            end
          endcase
        end
      end
      default: begin
        jk_j = '0;
        jk_k = '0;
      end
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Bench for jk_bank_seq: behavioural JK bank, directed scenarios, then randomized ops
// checked against a value-level model of each operation.
module tb_jk_bank_seq;
  localparam int W = 8;
  localparam int C = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_mask;
  logic [W-1:0] cmd_data;
  logic [C-1:0] cmd_cnt;
  logic         abort;
  logic [W-1:0] jk_q;
  logic [W-1:0] jk_j;
  logic [W-1:0] jk_k;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [1:0]   dbg_state;

  logic         preset_en;
  logic [W-1:0] preset_val;
  logic [W-1:0] bank_q;
  logic [W-1:0] model_q;
  logic [W-1:0] exp_q[$];

  int n_checks;
  int n_fail;

  jk_bank_seq #(.WIDTH(W), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .abort(abort), .jk_q(jk_q), .jk_j(jk_j), .jk_k(jk_k),
    .busy(busy), .done(done), .aborted(aborted), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // external JK bank: J/K set, reset, toggle or hold each bit
  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else           bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
  end
  assign jk_q = bank_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // value after one bank update of the given op
  function automatic logic [W-1:0] step(input logic [2:0] op, input logic [W-1:0] m,
                                        input logic [W-1:0] d, input logic [W-1:0] q);
    logic [W-1:0] s;
    case (op)
      3'd1: return q & ~m;
      3'd2: return q | m;
      3'd3: return q ^ m;
      3'd4: return (q & ~m) | (d & m);
      3'd5: begin
        s = q + 8'd1;
        return q ^ ((q ^ s) & m);
      end
      3'd6: begin
        s = (q << 1) | {7'd0, d[0]};
        return (q & ~m) | (s & m);
      end
      3'd7: begin
        s = (q >> 1) | {d[7], 7'd0};
        return (q & ~m) | (s & m);
      end
      default: return q;
    endcase
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one op; abort_at = EXEC cycle (1-based) on which abort is raised, 0 = none.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] m, input logic [W-1:0] d,
                        input logic [C-1:0] cnt, input int abort_at);
    int len, n_upd, exp_len, cyc;
    logic got, exp_ab;
    logic [W-1:0] r, fin;
    len    = (op >= 3'd5) ? int'(cnt) + 1 : 1;
    exp_ab = (abort_at != 0) && (abort_at <= len);
    n_upd  = exp_ab ? abort_at - 1 : len;
    exp_len = exp_ab ? abort_at : len;
    fin = model_q;
    for (int i = 0; i < n_upd; i++) fin = step(op, m, d, fin);
    exp_q.push_back(fin);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_data = d; cmd_cnt = cnt;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = W'($urandom);
    r = model_q;
    cyc = 0;
    got = 1'b0;
    while (cyc < 64) begin
      check("walk", {24'd0, bank_q}, {24'd0, r});
      if (done) begin
        got = 1'b1;
        break;
      end
      check("busy", {31'd0, busy}, 32'd1);
      cyc++;
      if (cyc <= n_upd) r = step(op, m, d, r);
      abort = (abort_at == cyc);
      @(negedge clk);
    end
    abort = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", cyc, exp_len);
    check("aborted", {31'd0, aborted}, {31'd0, exp_ab});
    check("ready_in_done", {31'd0, cmd_ready}, 32'd1);
    if (exp_q.size() > 0) check("result", {24'd0, bank_q}, {24'd0, exp_q.pop_front()});
    model_q = fin;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = '0; cmd_data = '0;
    cmd_cnt = '0; abort = 1'b0; preset_en = 1'b0; preset_val = '0;
    model_q = '0;

    // reset state and clearing of a preset bank by INIT
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_j", {24'd0, jk_j}, 32'h00);
    check("rst_k", {24'd0, jk_k}, 32'hFF);
    check("rst_bank_clr", {24'd0, bank_q}, 32'h00);
    preset_en = 1'b1; preset_val = 8'h5A;
    @(negedge clk);
    preset_en = 1'b0;
    check("preset", {24'd0, bank_q}, 32'h5A);
    rst_n = 1'b1;
    #1;
    check("init_ready", {31'd0, cmd_ready}, 32'd0);
    check("init_busy", {31'd0, busy}, 32'd1);
    check("init_k", {24'd0, jk_k}, 32'hFF);
    @(negedge clk);
    check("init_cleared", {24'd0, bank_q}, 32'h00);
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_jk", {24'd0, jk_j | jk_k}, 32'h00);
    check("idle_done", {31'd0, done}, 32'd0);

    // directed scenarios
    run_op(3'd4, 8'hFF, 8'hA5, 4'd0, 0);
    check("load_a5", {24'd0, bank_q}, 32'hA5);
    run_op(3'd4, 8'hFF, 8'hFE, 4'd0, 0);
    run_op(3'd5, 8'hFF, 8'h00, 4'd3, 0);
    check("inc_wrap", {24'd0, bank_q}, 32'h02);
    run_op(3'd4, 8'hFF, 8'h81, 4'd0, 0);
    run_op(3'd6, 8'h0F, 8'h01, 4'd1, 0);
    check("shl_mask", {24'd0, bank_q}, 32'h87);
    run_op(3'd4, 8'hFF, 8'h00, 4'd0, 0);
    run_op(3'd5, 8'hFF, 8'h00, 4'd15, 3);
    check("inc_abort", {24'd0, bank_q}, 32'h02);
    run_op(3'd7, 8'hFF, 8'h80, 4'd2, 3);
    run_op(3'd0, 8'hFF, 8'h00, 4'd0, 1);

    // abort ignored while idle
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_done", {31'd0, done}, 32'd0);
    abort = 1'b0;

    // back-to-back: SET waits with valid held, taken in TOG's done cycle
    run_op(3'd4, 8'hFF, 8'h3C, 4'd0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_mask = 8'hF0; cmd_data = 8'h00; cmd_cnt = 4'd0;
    @(negedge clk);
    cmd_op = 3'd2; cmd_mask = 8'hFF;
    check("b2b_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("b2b_tog", {24'd0, bank_q}, 32'hCC);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_set", {24'd0, bank_q}, 32'hFF);
    check("b2b_set_done", {31'd0, done}, 32'd1);
    model_q = 8'hFF;

    // reset mid-op: bank cleared, op lost, no done
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_mask = 8'hFF; cmd_cnt = 4'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_k", {24'd0, jk_k}, 32'hFF);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("mid_rst_bank", {24'd0, bank_q}, 32'h00);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_nodone", {31'd0, done}, 32'd0);
    model_q = '0;

    // randomized ops
    for (int t = 0; t < 60; t++) begin
      logic [2:0] op;
      logic [W-1:0] m, d;
      logic [C-1:0] cnt;
      int len, ab;
      op  = 3'($urandom_range(0, 7));
      m   = ($urandom_range(0, 2) == 0) ? 8'hFF : W'($urandom);
      d   = W'($urandom);
      cnt = C'($urandom_range(0, 6));
      len = (op >= 3'd5) ? int'(cnt) + 1 : 1;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_op(op, m, d, cnt, ab);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
